ram_arbiter: RTL

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter.sv | 119 +++++++++++
 1 files changed

// File: rtl/ram_arbiter.sv
// Round-robin arbiter giving NUM_REQ requesters shared access to one single-port RAM.
// Each transaction takes four cycles: IDLE (arbitrate), ACCESS, WAIT, RESP.
module ram_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int WIDTH      = 12,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                          clk,
  input  logic                          rstN,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            req_wrEn,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*WIDTH-1:0]      req_dataIn,
  output logic [NUM_REQ-1:0]            grant,
  output logic [NUM_REQ-1:0]            done,
  output logic [WIDTH-1:0]              rdData,
  output logic                          busy,
  output logic                          mem_wrEn,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  output logic [WIDTH-1:0]              mem_dataIn,
  input  logic [WIDTH-1:0]              mem_dataOut
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    RESP
  } state_t;

  state_t                r_state;
  logic [PW-1:0]         r_ptr;
  logic [PW-1:0]         r_owner;
  logic                  r_isWrite;

  logic [PW-1:0]         w_winner;
  logic [PW-1:0]         w_idx;
  logic                  w_found;
  logic [ADDR_WIDTH-1:0] w_addrArr [NUM_REQ];
  logic [WIDTH-1:0]      w_dataArr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign w_addrArr[g] = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_dataArr[g] = req_dataIn[g*WIDTH +: WIDTH];
  end

  // First requesting index at or above r_ptr, wrapping past NUM_REQ-1.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_idx = PW'((32'(r_ptr) + i) % NUM_REQ);
      if (!w_found && req[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_owner    <= '0;
      r_isWrite  <= 1'b0;
      grant      <= '0;
      done       <= '0;
      busy       <= 1'b0;
      rdData     <= '0;
      mem_wrEn   <= 1'b0;
      mem_addr   <= '0;
      mem_dataIn <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_owner    <= w_winner;
            r_isWrite  <= req_wrEn[w_winner];
            mem_wrEn   <= req_wrEn[w_winner];
            mem_addr   <= w_addrArr[w_winner];
            mem_dataIn <= w_dataArr[w_winner];
            grant      <= NUM_REQ'(1) << w_winner;
            busy       <= 1'b1;
            r_state    <= ACCESS;
          end
        end
        ACCESS: begin
          mem_wrEn <= 1'b0;
          r_state  <= WAIT;
        end
        WAIT: begin
          // RAM read data is valid here, one cycle after mem_addr was applied.
          if (!r_isWrite) begin
            rdData <= mem_dataOut;
          end
          done    <= grant;
          r_state <= RESP;
        end
        RESP: begin
          done  <= '0;
          grant <= '0;
          busy  <= 1'b0;
          if (r_owner == PW'(NUM_REQ - 1)) begin
            r_ptr <= '0;
          end else begin
            r_ptr <= r_owner + 1'b1;
          end
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
